branch_hazard_unit: RTL and testbench

Parametrised branch-operand hazard and forwarding controller for the five-stage MIPS pipeline with branches resolved in ID. It checks the rs/rt operands of a decode-stage branch (beq, bne, bgtz, regimm) against the destinations in EX, MEM and WB. It either selects a forwarding source for the ID comparator, or holds IF/ID for a computed number of cycles. Unlike the single-cycle negedge forwarding check it replaces, it supports configurable load latency, a counted multi-cycle hold FSM, a flush abort and a stall-cycle counter.

---
 rtl/branch_hazard_unit_if.sv | 41 ++++
 rtl/branch_hazard_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_hazard_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_unit_if.sv
// Branch-operand hazard bundle between the pipeline control and the hazard unit.
// The pipeline side is the master; the hazard unit is the slave.
interface branch_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_branch;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_flush;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_dst;
    logic              mem_regwrite;
    logic              mem_memread;
    logic [REG_AW-1:0] mem_dst;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_dst;
    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              busy;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_branch, id_uses_rt, id_rs, id_rt, id_flush,
        output ex_regwrite, ex_memread, ex_dst,
        output mem_regwrite, mem_memread, mem_dst,
        output wb_regwrite, wb_dst,
        input  stall, fwd_a, fwd_b, busy, stall_cycles
    );

    modport slave (
        input  id_branch, id_uses_rt, id_rs, id_rt, id_flush,
        input  ex_regwrite, ex_memread, ex_dst,
        input  mem_regwrite, mem_memread, mem_dst,
        input  wb_regwrite, wb_dst,
        output stall, fwd_a, fwd_b, busy, stall_cycles
    );
endinterface

// File: rtl/branch_hazard_unit.sv
// ID-stage branch operand hazard unit: selects comparator forwarding sources
// or holds IF/ID for a counted number of cycles while a producer drains.
module branch_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic                  clock,
    input logic                  reset_n,
    branch_hazard_unit_if.slave  bus
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    localparam logic [3:0] NEED_EX_ALU = 4'd1;
    localparam logic [3:0] NEED_EX_LD  = 4'(LOAD_LAT + 1);
    localparam logic [3:0] NEED_MEM_LD = 4'(LOAD_LAT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_rem;
    logic [2:0]       w_rem_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic       w_ex_rs;
    logic       w_ex_rt;
    logic       w_mem_rs;
    logic       w_mem_rt;
    logic       w_wb_rs;
    logic       w_wb_rt;
    logic [3:0] w_need_rs;
    logic [3:0] w_need_rt;
    logic [3:0] w_need;
    logic       w_eval;
    logic       w_stall;
    logic       w_busy;
    logic       w_stall_out;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A write to r0 never creates a dependency, so src==0 masks every match.
    assign w_ex_rs = bus.ex_regwrite && (bus.ex_dst == bus.id_rs)
                     && (bus.id_rs != '0);
    assign w_ex_rt = bus.id_uses_rt && bus.ex_regwrite
                     && (bus.ex_dst == bus.id_rt) && (bus.id_rt != '0);
    assign w_mem_rs = bus.mem_regwrite && (bus.mem_dst == bus.id_rs)
                      && (bus.id_rs != '0);
    assign w_mem_rt = bus.id_uses_rt && bus.mem_regwrite
                      && (bus.mem_dst == bus.id_rt) && (bus.id_rt != '0);
    assign w_wb_rs = bus.wb_regwrite && (bus.wb_dst == bus.id_rs)
                     && (bus.id_rs != '0);
    assign w_wb_rt = bus.id_uses_rt && bus.wb_regwrite
                     && (bus.wb_dst == bus.id_rt) && (bus.id_rt != '0);

    always_comb begin
        w_need_rs = 4'd0;
        if (w_ex_rs)
            w_need_rs = bus.ex_memread ? NEED_EX_LD : NEED_EX_ALU;
        else if (w_mem_rs && bus.mem_memread)
            w_need_rs = NEED_MEM_LD;
    end

    always_comb begin
        w_need_rt = 4'd0;
        if (w_ex_rt)
            w_need_rt = bus.ex_memread ? NEED_EX_LD : NEED_EX_ALU;
        else if (w_mem_rt && bus.mem_memread)
            w_need_rt = NEED_MEM_LD;
    end

    assign w_need = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
    assign w_eval = bus.id_branch && !bus.id_flush;

    // r_rem counts HOLD cycles still owed after the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall     = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_eval && (w_need != 4'd0)) begin
                    w_stall = 1'b1;
                    if (w_need > 4'd1) begin
                        w_state_nxt = S_HOLD;
                        w_rem_nxt   = 3'(w_need - 4'd1);
                    end
                end
            end
            S_HOLD: begin
                w_busy = 1'b1;
                if (bus.id_flush) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = 3'd0;
                end else begin
                    w_stall = 1'b1;
                    if (r_rem <= 3'd1) begin
                        w_state_nxt = S_IDLE;
                        w_rem_nxt   = 3'd0;
                    end else begin
                        w_rem_nxt = r_rem - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Gating with reset lets a mid-hold reset drop stall without a clock edge.
    assign w_stall_out = reset_n && w_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (w_stall_out && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    always_comb begin
        w_fwd_a = 2'b00;
        if (bus.id_branch && !w_stall_out) begin
            unique case (1'b1)
                (w_mem_rs && !bus.mem_memread): w_fwd_a = 2'b01;
                (!(w_mem_rs && !bus.mem_memread) && w_wb_rs): w_fwd_a = 2'b10;
                default: w_fwd_a = 2'b00;
            endcase
        end
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (bus.id_branch && !w_stall_out) begin
            unique case (1'b1)
                (w_mem_rt && !bus.mem_memread): w_fwd_b = 2'b01;
                (!(w_mem_rt && !bus.mem_memread) && w_wb_rt): w_fwd_b = 2'b10;
                default: w_fwd_b = 2'b00;
            endcase
        end
    end

    assign bus.stall        = w_stall_out;
    assign bus.busy         = reset_n && w_busy;
    assign bus.fwd_a        = w_fwd_a;
    assign bus.fwd_b        = w_fwd_b;
    assign bus.stall_cycles = r_cnt;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Bench for branch_hazard_unit: three configurations driven in lockstep and
// compared against a pending-stall-count model of the hazard rules.
module tb_branch_hazard_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       t_branch, t_uses_rt, t_flush;
    logic       t_exw, t_exr, t_memw, t_memr, t_wbw;
    logic [4:0] t_rs, t_rt, t_exd, t_memd, t_wbd;

    logic [31:0] o_stall [3];
    logic [31:0] o_busy  [3];
    logic [31:0] o_fa    [3];
    logic [31:0] o_fb    [3];
    logic [31:0] o_cnt   [3];

    localparam int LATS [3] = '{1, 3, 1};
    localparam int CMAX [3] = '{65535, 65535, 3};

    int checks = 0;
    int errors = 0;
    int m_left [3];
    int m_cnt  [3];

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int LAT = (k == 1) ? 3 : 1;
        localparam int CW  = (k == 2) ? 2 : 16;
        branch_hazard_unit_if #(.REG_AW(5), .CNT_W(CW)) bus ();
        assign bus.id_branch    = t_branch;
        assign bus.id_uses_rt   = t_uses_rt;
        assign bus.id_rs        = t_rs;
        assign bus.id_rt        = t_rt;
        assign bus.id_flush     = t_flush;
        assign bus.ex_regwrite  = t_exw;
        assign bus.ex_memread   = t_exr;
        assign bus.ex_dst       = t_exd;
        assign bus.mem_regwrite = t_memw;
        assign bus.mem_memread  = t_memr;
        assign bus.mem_dst      = t_memd;
        assign bus.wb_regwrite  = t_wbw;
        assign bus.wb_dst       = t_wbd;
        branch_hazard_unit #(
            .REG_AW(5), .LOAD_LAT(LAT), .CNT_W(CW)
        ) dut (
            .clock(clk), .reset_n(rst_n), .bus(bus)
        );
        assign o_stall[k] = 32'(bus.stall);
        assign o_busy[k]  = 32'(bus.busy);
        assign o_fa[k]    = 32'(bus.fwd_a);
        assign o_fb[k]    = 32'(bus.fwd_b);
        assign o_cnt[k]   = 32'(bus.stall_cycles);
    end

    function automatic int op_need(logic [4:0] s, int lat);
        if (s == 0) return 0;
        if (t_exw && t_exd == s) return t_exr ? lat + 1 : 1;
        if (t_memw && t_memr && t_memd == s) return lat;
        return 0;
    endfunction

    function automatic int op_fwd(logic [4:0] s);
        if (s == 0) return 0;
        if (t_memw && !t_memr && t_memd == s) return 1;
        if (t_wbw && t_wbd == s) return 2;
        return 0;
    endfunction

    task automatic chk(string tag, int k, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic clr();
        t_branch = 0; t_uses_rt = 0; t_flush = 0;
        t_exw = 0; t_exr = 0; t_memw = 0; t_memr = 0; t_wbw = 0;
        t_rs = 0; t_rt = 0; t_exd = 0; t_memd = 0; t_wbd = 0;
    endtask

    task automatic step(string tag);
        int n [3];
        int es [3];
        #2;
        for (int k = 0; k < 3; k++) begin
            int nb;
            n[k] = op_need(t_rs, LATS[k]);
            nb = t_uses_rt ? op_need(t_rt, LATS[k]) : 0;
            if (nb > n[k]) n[k] = nb;
            if (!rst_n) es[k] = 0;
            else if (m_left[k] > 0) es[k] = !t_flush;
            else es[k] = (t_branch && !t_flush && n[k] > 0) ? 1 : 0;
            chk({tag, "_stall"}, k, o_stall[k], es[k]);
            chk({tag, "_busy"}, k, o_busy[k],
                (rst_n && m_left[k] > 0) ? 1 : 0);
            chk({tag, "_fwda"}, k, o_fa[k],
                (es[k] == 1 || !t_branch) ? 0 : op_fwd(t_rs));
            chk({tag, "_fwdb"}, k, o_fb[k],
                (es[k] == 1 || !t_branch || !t_uses_rt) ? 0 : op_fwd(t_rt));
            chk({tag, "_cnt"}, k, o_cnt[k], m_cnt[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_left[k] = 0;
                m_cnt[k]  = 0;
            end else begin
                if (es[k] == 1 && m_cnt[k] < CMAX[k]) m_cnt[k]++;
                if (m_left[k] > 0) m_left[k] = t_flush ? 0 : m_left[k] - 1;
                else m_left[k] = (es[k] == 1) ? n[k] - 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0;
            m_cnt[k]  = 0;
        end
        clr();
        @(negedge clk);
        step("reset");
        rst_n = 1;

        t_branch = 1; t_rs = 8; t_exw = 1; t_exd = 8;
        step("alu_ex");
        t_exw = 0; t_exd = 0; t_memw = 1; t_memd = 8;
        step("alu_fwd");
        clr();

        t_branch = 1; t_uses_rt = 1; t_rs = 3; t_rt = 9;
        t_exw = 1; t_exr = 1; t_exd = 9;
        step("ld_ex");
        t_exw = 0; t_exr = 0; t_exd = 0;
        t_memw = 1; t_memr = 1; t_memd = 9;
        step("ld_mem");
        t_memw = 0; t_memr = 0; t_memd = 0; t_wbw = 1; t_wbd = 9;
        step("ld_wb");
        step("ld_wb2");
        t_wbw = 0; t_wbd = 0;
        step("ld_done");
        clr();

        t_branch = 1; t_exw = 1; t_exd = 0; t_rs = 0;
        step("zero_reg");
        t_rs = 1; t_rt = 5; t_exd = 5; t_uses_rt = 0;
        step("bgtz_rt");
        t_exw = 0; t_wbw = 1; t_wbd = 5;
        step("bgtz_fwd");
        clr();

        t_branch = 1; t_uses_rt = 1; t_rs = 6; t_rt = 7;
        t_memw = 1; t_memr = 1; t_memd = 6;
        t_exw = 1; t_exr = 1; t_exd = 7;
        step("dual0");
        for (int i = 0; i < 4; i++) step("dual_hold");
        clr();

        t_branch = 1; t_rs = 10; t_exw = 1; t_exr = 1; t_exd = 10;
        step("fl_start");
        t_flush = 1;
        step("fl_hold");
        clr();
        step("fl_idle");

        t_branch = 1; t_rs = 11; t_exw = 1; t_exr = 1; t_exd = 11;
        step("rs_start");
        #2;
        rst_n = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_rst_stall", k, o_stall[k], 0);
            chk("async_rst_cnt", k, o_cnt[k], 0);
            m_left[k] = 0;
            m_cnt[k]  = 0;
        end
        @(negedge clk);
        step("in_reset");
        rst_n = 1;
        clr();

        for (int i = 0; i < 5; i++) begin
            clr();
            t_branch = 1; t_rs = 12; t_exw = 1; t_exd = 12;
            step("sat");
            clr();
            step("sat_gap");
        end
        chk("cnt_saturated", 2, o_cnt[2], 3);
        chk("cnt_wide", 0, o_cnt[0], 5);

        for (int i = 0; i < 400; i++) begin
            t_branch  = 1'($urandom_range(0, 3) != 0);
            t_uses_rt = 1'($urandom_range(0, 1));
            t_flush   = 1'($urandom_range(0, 9) == 0);
            t_rs  = 5'($urandom_range(0, 3));
            t_rt  = 5'($urandom_range(0, 3));
            t_exw = 1'($urandom_range(0, 1));
            t_exr = 1'($urandom_range(0, 2) == 0);
            t_exd = 5'($urandom_range(0, 3));
            t_memw = 1'($urandom_range(0, 1));
            t_memr = 1'($urandom_range(0, 2) == 0);
            t_memd = 5'($urandom_range(0, 3));
            t_wbw = 1'($urandom_range(0, 1));
            t_wbd = 5'($urandom_range(0, 3));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
